// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception/ERET controller: prioritise, commit to CP0, flush, redirect fetch
module exc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_in_delay_slot,
    input  logic        mem_is_eret,
    input  logic        stall_i,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_addr,
    input  logic        if_adel,
    input  logic        id_ri,
    input  logic        id_syscall,
    input  logic        id_break,
    input  logic        ex_ov,
    input  logic        mem_adel,
    input  logic        mem_ades,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        mem_we_kill_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic        exc_valid_o,
    output logic        eret_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_pc_o,
    output logic [31:0] exc_badvaddr_o,
    output logic        exc_bd_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        cnt;

    logic [4:0]  lat_code;
    logic [31:0] lat_pc;
    logic [31:0] lat_badvaddr;
    logic [31:0] lat_epc;
    logic        lat_bd;
    logic        lat_is_exc;

    logic        int_pend;
    logic        exc_hit;
    logic        trigger;
    logic [4:0]  code_sel;
    logic [31:0] badvaddr_sel;

    // Only IE/EXL, the IM/IP byte and nothing else of Status/Cause matter here.
    logic        unused_cp0;
    assign unused_cp0 = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    assign int_pend = cp0_status[0] & ~cp0_status[1] & (|(cp0_cause[15:8] & cp0_status[15:8]));
    assign exc_hit  = int_pend | if_adel | id_ri | id_syscall | id_break | ex_ov | mem_adel | mem_ades;
    assign trigger  = (state == IDLE) & mem_valid & ~stall_i & (exc_hit | mem_is_eret);

    // The oldest pipeline stage wins; BadVAddr follows the winning cause only.
    always_comb begin
        code_sel     = CODE_INT;
        badvaddr_sel = 32'd0;
        if (int_pend) begin
            code_sel = CODE_INT;
        end else if (if_adel) begin
            code_sel     = CODE_ADEL;
            badvaddr_sel = mem_pc;
        end else if (id_ri) begin
            code_sel = CODE_RI;
        end else if (id_syscall) begin
            code_sel = CODE_SYS;
        end else if (id_break) begin
            code_sel = CODE_BP;
        end else if (ex_ov) begin
            code_sel = CODE_OV;
        end else if (mem_adel) begin
            code_sel     = CODE_ADEL;
            badvaddr_sel = mem_addr;
        end else if (mem_ades) begin
            code_sel     = CODE_ADES;
            badvaddr_sel = mem_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 1'b0;
            lat_code     <= 5'd0;
            lat_pc       <= 32'd0;
            lat_badvaddr <= 32'd0;
            lat_epc      <= 32'd0;
            lat_bd       <= 1'b0;
            lat_is_exc   <= 1'b0;
        end else begin
            if (trigger) begin
                lat_code     <= code_sel;
                lat_pc       <= mem_pc;
                lat_badvaddr <= badvaddr_sel;
                lat_epc      <= cp0_epc;
                lat_bd       <= mem_in_delay_slot;
                lat_is_exc   <= exc_hit;
            end
            if (state == COMMIT) begin
                cnt <= 1'b0;
            end else if (state == FLUSH) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = COMMIT;
            COMMIT:  state_next = FLUSH;
            FLUSH:   if (cnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every output is forced low while rst is high, independent of the clock.
    always_comb begin
        mem_we_kill_o    = 1'b0;
        flush_o          = 1'b0;
        busy_o           = 1'b0;
        exc_valid_o      = 1'b0;
        eret_o           = 1'b0;
        exc_code_o       = 5'd0;
        exc_pc_o         = 32'd0;
        exc_badvaddr_o   = 32'd0;
        exc_bd_o         = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        if (!rst) begin
            mem_we_kill_o = trigger;
            flush_o       = trigger | (state != IDLE);
            busy_o        = (state != IDLE);
            if (state == COMMIT) begin
                exc_valid_o    = lat_is_exc;
                eret_o         = ~lat_is_exc;
                exc_code_o     = lat_code;
                exc_pc_o       = lat_pc;
                exc_badvaddr_o = lat_badvaddr;
                exc_bd_o       = lat_bd;
            end
            if (state == FLUSH && cnt) begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = lat_is_exc ? EXC_VECTOR : lat_epc;
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - randomized and directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_in_delay_slot, mem_is_eret, stall_i;
    logic [31:0] mem_pc, mem_addr;
    logic        if_adel, id_ri, id_syscall, id_break, ex_ov, mem_adel, mem_ades;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        mem_we_kill_o, flush_o, busy_o, exc_valid_o, eret_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_pc_o, exc_badvaddr_o;
    logic        exc_bd_o, redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int failures = 0;

    // Reference model: phase counts cycles since the accepted instruction (0 = idle).
    int          ph;
    bit          m_exc;
    logic [4:0]  m_code;
    logic [31:0] m_pc, m_bad, m_epc;
    bit          m_bd;

    exc_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_in_delay_slot(mem_in_delay_slot),
        .mem_is_eret(mem_is_eret), .stall_i(stall_i),
        .mem_pc(mem_pc), .mem_addr(mem_addr),
        .if_adel(if_adel), .id_ri(id_ri), .id_syscall(id_syscall), .id_break(id_break),
        .ex_ov(ex_ov), .mem_adel(mem_adel), .mem_ades(mem_ades),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .mem_we_kill_o(mem_we_kill_o), .flush_o(flush_o), .busy_o(busy_o),
        .exc_valid_o(exc_valid_o), .eret_o(eret_o), .exc_code_o(exc_code_o),
        .exc_pc_o(exc_pc_o), .exc_badvaddr_o(exc_badvaddr_o), .exc_bd_o(exc_bd_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit int_pending();
        return cp0_status[0] && !cp0_status[1] && ((cp0_cause[15:8] & cp0_status[15:8]) != 8'd0);
    endfunction

    // Walk the causes oldest-first; returns 1 if any cause is present.
    task automatic pick_cause(output bit hit, output logic [4:0] code, output logic [31:0] bad);
        bit          flags [8];
        logic [4:0]  codes [8];
        flags = '{int_pending(), if_adel, id_ri, id_syscall, id_break, ex_ov, mem_adel, mem_ades};
        codes = '{5'd0, 5'd4, 5'd10, 5'd8, 5'd9, 5'd12, 5'd4, 5'd5};
        hit = 0; code = 5'd0; bad = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (flags[i] && !hit) begin
                hit  = 1;
                code = codes[i];
                if (i == 1) bad = mem_pc;
                else if (i >= 6) bad = mem_addr;
            end
        end
    endtask

    task automatic clear_inputs();
        mem_valid = 0; mem_in_delay_slot = 0; mem_is_eret = 0; stall_i = 0;
        mem_pc = 32'h0; mem_addr = 32'h0;
        if_adel = 0; id_ri = 0; id_syscall = 0; id_break = 0; ex_ov = 0; mem_adel = 0; mem_ades = 0;
        cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    endtask

    task automatic random_inputs();
        mem_valid         = ($urandom_range(3) != 0);
        mem_in_delay_slot = $urandom_range(1);
        mem_is_eret       = ($urandom_range(5) == 0);
        stall_i           = ($urandom_range(4) == 0);
        mem_pc            = $urandom & 32'hFFFF_FFFC;
        mem_addr          = $urandom;
        if_adel    = ($urandom_range(15) == 0);
        id_ri      = ($urandom_range(15) == 0);
        id_syscall = ($urandom_range(15) == 0);
        id_break   = ($urandom_range(15) == 0);
        ex_ov      = ($urandom_range(15) == 0);
        mem_adel   = ($urandom_range(15) == 0);
        mem_ades   = ($urandom_range(15) == 0);
        cp0_status = $urandom & 32'hFFFF_FFFC;
        cp0_status[0] = ($urandom_range(3) != 0);
        cp0_status[1] = ($urandom_range(3) == 0);
        cp0_cause  = ($urandom_range(5) == 0) ? (32'h100 << $urandom_range(7)) : 32'h0;
        cp0_epc    = $urandom;
    endtask

    // Called just after a negedge with inputs applied: check, then advance one clock.
    task automatic step();
        bit          hit, trig;
        logic [4:0]  code;
        logic [31:0] bad;
        pick_cause(hit, code, bad);
        trig = !rst && ph == 0 && mem_valid && !stall_i && (hit || mem_is_eret);
        #1;
        check("kill",       mem_we_kill_o,    trig);
        check("flush",      flush_o,          !rst && (trig || ph != 0));
        check("busy",       busy_o,           !rst && ph != 0);
        check("exc_valid",  exc_valid_o,      !rst && ph == 1 && m_exc);
        check("eret",       eret_o,           !rst && ph == 1 && !m_exc);
        check("code",       exc_code_o,       (!rst && ph == 1) ? m_code : 5'd0);
        check("exc_pc",     exc_pc_o,         (!rst && ph == 1) ? m_pc : 32'd0);
        check("badvaddr",   exc_badvaddr_o,   (!rst && ph == 1) ? m_bad : 32'd0);
        check("bd",         exc_bd_o,         !rst && ph == 1 && m_bd);
        check("redir_v",    redirect_valid_o, !rst && ph == 3);
        check("redir_pc",   redirect_pc_o,    (!rst && ph == 3) ? (m_exc ? 32'hBFC0_0380 : m_epc) : 32'd0);
        @(posedge clk);
        if (rst) begin
            ph = 0; m_exc = 0; m_code = 0; m_pc = 0; m_bad = 0; m_epc = 0; m_bd = 0;
        end else if (trig) begin
            ph = 1; m_exc = hit; m_code = code; m_pc = mem_pc; m_bad = bad;
            m_epc = cp0_epc; m_bd = mem_in_delay_slot;
        end else if (ph != 0) begin
            ph = (ph + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        clear_inputs();
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        ph = 0; m_exc = 0; m_code = 0; m_pc = 0; m_bad = 0; m_epc = 0; m_bd = 0;
        rst = 1;
        clear_inputs();
        mem_valid = 1; id_syscall = 1;
        step();
        step();
        rst = 0;

        // Syscall accepted on the first edge after reset; redirect three cycles later.
        mem_valid = 1; id_syscall = 1; mem_pc = 32'h8000_1000;
        step();
        clear_inputs();
        check("sys_code_const", exc_code_o, 5'd8);
        check("sys_pc_const", exc_pc_o, 32'h8000_1000);
        step(); step();
        check("sys_redir_const", redirect_pc_o, 32'hBFC0_0380);
        step(); step();

        clear_inputs(); mem_valid = 1; mem_ades = 1; mem_addr = 32'h3;
        step();
        check("ades_bad_const", exc_badvaddr_o, 32'h3);
        drain();
        clear_inputs(); mem_valid = 1; ex_ov = 1; mem_adel = 1; mem_addr = 32'h11;
        step(); drain();

        clear_inputs(); mem_valid = 1; mem_is_eret = 1; cp0_epc = 32'h8000_2000;
        step();
        check("eret_const", eret_o, 1'b1);
        drain();
        clear_inputs(); mem_valid = 1; mem_is_eret = 1; id_break = 1;
        step(); drain();

        clear_inputs(); mem_valid = 1; mem_in_delay_slot = 1;
        cp0_status = 32'h401; cp0_cause = 32'h400;
        step(); drain();
        clear_inputs(); mem_valid = 1; cp0_status = 32'h403; cp0_cause = 32'h400;
        step(); drain();

        // Second exception while busy is ignored.
        clear_inputs(); mem_valid = 1; id_ri = 1;
        step(); step(); step(); step(); step(); step();
        drain();

        // Stall holds the exception off until released.
        clear_inputs(); mem_valid = 1; id_break = 1; stall_i = 1;
        step(); step(); step();
        stall_i = 0;
        step(); drain();

        // Reset asserted mid-COMMIT clears outputs immediately.
        clear_inputs(); mem_valid = 1; if_adel = 1; mem_pc = 32'h8000_0042;
        step();
        rst = 1;
        step();
        rst = 0;
        step(); drain();

        for (int n = 0; n < 2000; n++) begin
            random_inputs();
            if ($urandom_range(199) == 0) rst = 1;
            step();
            rst = 0;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  async active-high reset.
REQ-004 mem_valid, mem_in_delay_slot, mem_is_eret, stall_i  input  1 each  MEM-stage instruction valid, in branch delay slot, is ERET, pipeline stall.
REQ-005 mem_pc, mem_addr  input  32 each  MEM-stage instruction PC, data access address.
REQ-006 if_adel, id_ri, id_syscall, id_break, ex_ov, mem_adel, mem_ades  input  1 each  exception flags carried down the pipeline to MEM.
REQ-007 cp0_status, cp0_cause, cp0_epc  input  32 each  current CP0 Status, Cause, EPC.
REQ-008 mem_we_kill_o, flush_o, busy_o  output  1 each  suppress DM write, squash pipeline, FSM not IDLE.
REQ-009 exc_valid_o, eret_o  output  1 each  one-cycle commit pulses to CP0.
REQ-010 exc_code_o  output  5  ExcCode to CP0.
REQ-011 exc_pc_o, exc_badvaddr_o  output  32 each  PC and BadVAddr to CP0.
REQ-012 exc_bd_o  output  1  delay-slot flag to CP0.
REQ-013 redirect_valid_o  output  1  one-cycle fetch-redirect pulse.
REQ-014 redirect_pc_o  output  32  fetch-redirect target.

Function
REQ-015 int_pend SHALL = cp0_status[0] & ~cp0_status[1] & |(cp0_cause[15:8] & cp0_status[15:8]).
REQ-016 Priority, highest first: Int(0), if_adel AdEL(4), id_ri RI(10), id_syscall Sys(8), id_break Bp(9), ex_ov Ov(12), mem_adel AdEL(4), mem_ades AdES(5).
REQ-017 exc_hit SHALL = int_pend or any flag in REQ-006; trigger SHALL = state IDLE & mem_valid & ~stall_i & (exc_hit | mem_is_eret).
REQ-018 mem_we_kill_o SHALL equal trigger combinationally in the same cycle.
REQ-019 flush_o SHALL be 1 when trigger is 1 or state != IDLE; else 0.
REQ-020 On trigger, at the clock edge, SHALL latch: code per REQ-016, mem_pc, mem_in_delay_slot, kind (EXC if exc_hit, else ERET), cp0_epc.
REQ-021 BadVAddr latch: mem_pc for if_adel; mem_addr for mem_adel/mem_ades; otherwise 0.
REQ-022 FSM states IDLE, COMMIT, FLUSH; IDLE->COMMIT on trigger; COMMIT->FLUSH always; FLUSH->IDLE when cnt==1, else cnt increments.
REQ-023 cnt SHALL be 1 bit, cleared on COMMIT->FLUSH; FLUSH lasts exactly 2 cycles.
REQ-024 In COMMIT: exc_valid_o=1 if kind EXC, else eret_o=1; exc_code_o, exc_pc_o, exc_bd_o, exc_badvaddr_o driven from latches.
REQ-025 Outside COMMIT: exc_valid_o=0, eret_o=0, exc_* outputs 0.
REQ-026 redirect_valid_o SHALL be 1 in the FLUSH cycle with cnt==1 only.
REQ-027 redirect_pc_o SHALL be 32'hBFC00380 for EXC and the latched EPC for ERET while redirect_valid_o is 1; 0 otherwise.
REQ-028 Exception and mem_is_eret in the same instruction SHALL be handled as EXC; no eret_o.
REQ-029 While busy_o=1 all inputs SHALL be ignored; no new trigger until IDLE.
REQ-030 stall_i=1 SHALL block a trigger and hold IDLE; stall_i SHALL NOT affect COMMIT/FLUSH progress.
REQ-031 Trigger-to-redirect latency SHALL be 3 cycles after the trigger edge: COMMIT, FLUSH0, FLUSH1 with redirect.

Reset
REQ-032 rst=1 SHALL force IDLE, cnt=0, clear all latches, and drive every output to 0 asynchronously, including mid-COMMIT or mid-FLUSH.
REQ-033 After rst deasserts, a trigger SHALL be accepted on the first clk edge.

Verification
REQ-034 mem_valid=1, id_syscall=1, mem_pc=0x80001000 -> kill and flush in cycle 0; cycle 1 exc_valid_o=1, code 8, pc 0x80001000; cycle 3 redirect 0xBFC00380.
REQ-035 mem_ades=1, mem_addr=0x00000003 -> code 5, badvaddr 0x00000003; ex_ov=1 together with mem_adel=1 -> code 12.
REQ-036 mem_is_eret=1, cp0_epc=0x80002000 -> cycle 1 eret_o=1, exc_valid_o=0; cycle 3 redirect 0x80002000; eret plus id_break -> code 9, no eret_o.
REQ-037 status=0x00000401, cause=0x00000400, mem_valid=1, mem_in_delay_slot=1 -> code 0, exc_bd_o=1; status EXL bit set -> no trigger.
REQ-038 Second exception during FLUSH -> ignored; stall_i=1 with exception -> no trigger until stall_i=0; rst asserted in COMMIT -> all outputs 0 immediately.
